mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control.sv | 204 ++++++++++++++++++++
 tb/tb_mc_control.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multi-cycle RISC-V style controller: sequences fetch, decode, execute, memory and writeback.
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap on unknown opcodes instead of treating them as NOPs.
module mc_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic [31:0] alu_result,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_control,
    output logic [2:0]  alu_funct3,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic        illegal_instr
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_READ, MEM_WB,
        MEM_WRITE, ALU_WB, BRANCH, JAL
`ifdef MC_ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

    state_t      state_reg, state_next;
    logic [6:0]  opcode_reg;
    logic [2:0]  funct3_reg;
    logic        bit30_reg;
    logic        latch_en;
    logic        zero;

    // Only opcode, funct3 and bit 30 steer the controller.
    wire unused_rdata = &{1'b0, mem_rdata[31], mem_rdata[29:15], mem_rdata[11:7]};

    assign zero     = (alu_result == 32'd0);
    assign latch_en = (state_reg == FETCH) && mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= FETCH;
            opcode_reg <= 7'd0;
            funct3_reg <= 3'd0;
            bit30_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (latch_en) begin
                opcode_reg <= mem_rdata[6:0];
                funct3_reg <= mem_rdata[14:12];
                bit30_reg  <= mem_rdata[30];
            end
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_reg <= 1'b0;
        end else if (state_next == TRAP) begin
            illegal_reg <= 1'b1;
        end
    end

    assign illegal_instr = illegal_reg;
`else
    assign illegal_instr = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_control = 2'b00;
        alu_funct3  = 3'b000;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;

        case (state_reg)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                // Precompute the branch/jump target PC+imm into ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode_reg)
                    OP_R:               state_next = EXEC_R;
                    OP_I:               state_next = EXEC_I;
                    OP_LOAD, OP_STORE:  state_next = MEM_ADDR;
                    OP_BRANCH:          state_next = BRANCH;
                    OP_JAL:             state_next = JAL;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:            state_next = TRAP;
`else
                    default:            state_next = FETCH;
`endif
                endcase
            end
            EXEC_R: begin
                alu_src_a   = 2'b10;
                alu_funct3  = funct3_reg;
                alu_control = bit30_reg ? 2'b11 : 2'b01;
                state_next  = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_funct3 = funct3_reg;
                // slti/sltiu and srai need the subtract/arith flavour of the ALU.
                if ((funct3_reg == 3'b010) || (funct3_reg == 3'b011) ||
                    ((funct3_reg == 3'b101) && bit30_reg)) begin
                    alu_control = 2'b11;
                end else begin
                    alu_control = 2'b01;
                end
                state_next = ALU_WB;
            end
            ALU_WB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = (opcode_reg == OP_LOAD) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_next = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                state_next = FETCH;
            end
            MEM_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = 2'b11;
                pc_write    = ((funct3_reg == 3'b000) && zero) ||
                              ((funct3_reg == 3'b001) && !zero);
                state_next  = FETCH;
            end
            JAL: begin
                // ALUOut still holds the target; the ALU forms oldPC+4 for the link.
                pc_write   = 1'b1;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                state_next = ALU_WB;
            end
            default: begin
                state_next = state_reg;
            end
        endcase

        // Outputs stay quiet for the whole time reset is held, dropping any request in flight.
        if (!rst_n) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            adr_src     = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            reg_write   = 1'b0;
            alu_control = 2'b00;
            alu_funct3  = 3'b000;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            result_src  = 2'b00;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: per-instruction expected output sequences are queued
// by the driver and compared cycle by cycle by an independent monitor.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic [31:0] alu_result = 32'd0;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_control, alu_src_a, alu_src_b, result_src;
    logic [2:0]  alu_funct3;
    logic        illegal_instr;

    mc_control dut (
        .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .alu_result(alu_result), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_control(alu_control), .alu_funct3(alu_funct3), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    // Packed view: {req,we,adr,irw,pcw,rw,ctl[2],f3[3],src_a[2],src_b[2],res[2],ill}
    logic [17:0] act;
    assign act = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, alu_control,
                  alu_funct3, alu_src_a, alu_src_b, result_src, illegal_instr};

    logic [17:0] expq[$];
    string       nameq[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [17:0] mon_e;
    string       mon_n;

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            mon_n = nameq.pop_front();
            n_vec++;
            if (act !== mon_e) begin
                n_bad++;
                $display("FAIL %s: got %05h expected %05h", mon_n, act, mon_e);
            end
        end
    end

    task automatic check_now(input logic [17:0] e, input string nm);
        n_vec++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s (direct): got %05h expected %05h", nm, act, e);
        end
    endtask

    function automatic logic [17:0] mk(input logic req, we, adr, irw, pcw, rw,
                                       input logic [1:0] ctl, input logic [2:0] f3,
                                       input logic [1:0] sa, sb, rs, input logic ill);
        return {req, we, adr, irw, pcw, rw, ctl, f3, sa, sb, rs, ill};
    endfunction

    task automatic cyc(input logic [31:0] rd, input logic rdy, input logic [31:0] alu,
                       input logic rn, input logic [17:0] e, input string nm);
        mem_rdata  = rd;
        mem_ready  = rdy;
        alu_result = alu;
        rst_n      = rn;
        expq.push_back(e);
        nameq.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        // mem_ready high while in reset must not advance anything.
        cyc($urandom, 1'b1, $urandom, 1'b0, 18'd0, "reset");
        cyc($urandom, 1'b1, $urandom, 1'b0, 18'd0, "reset");
        check_now(18'd0, "reset_state");
    endtask

    // Reference: the output sequence one instruction produces, from the controller's rules.
    // abort >= 0 asserts reset after that many unanswered store cycles.
    task automatic run_instr(input logic [31:0] instr, input int fw, input int mw,
                             input bit br_zero, input int abort);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        b30;
        logic        rdy;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [1:0]  ctl;
        op  = instr[6:0];
        f3  = instr[14:12];
        b30 = instr[30];
        for (int i = 0; i <= fw; i++) begin
            rdy = (i == fw);
            rd  = rdy ? instr : $urandom;
            cyc(rd, rdy, $urandom, 1'b1,
                mk(1, 0, 0, rdy, rdy, 0, 2'b00, 3'b000, 2'b00, 2'b10, 2'b10, 0), "fetch");
        end
        cyc($urandom, 1'($urandom), $urandom, 1'b1,
            mk(0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b01, 2'b00, 0), "decode");
        case (op)
            7'b0110011: begin
                ctl = b30 ? 2'b11 : 2'b01;
                cyc($urandom, 1'($urandom), $urandom, 1'b1,
                    mk(0, 0, 0, 0, 0, 0, ctl, f3, 2'b10, 2'b00, 2'b00, 0), "exec_r");
                cyc($urandom, 1'($urandom), $urandom, 1'b1,
                    mk(0, 0, 0, 0, 0, 1, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0), "alu_wb");
            end
            7'b0010011: begin
                ctl = (f3 == 3'b010 || f3 == 3'b011 || (f3 == 3'b101 && b30)) ? 2'b11 : 2'b01;
                cyc($urandom, 1'($urandom), $urandom, 1'b1,
                    mk(0, 0, 0, 0, 0, 0, ctl, f3, 2'b10, 2'b01, 2'b00, 0), "exec_i");
                cyc($urandom, 1'($urandom), $urandom, 1'b1,
                    mk(0, 0, 0, 0, 0, 1, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0), "alu_wb");
            end
            7'b0000011, 7'b0100011: begin
                cyc($urandom, 1'($urandom), $urandom, 1'b1,
                    mk(0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 2'b01, 2'b00, 0), "mem_addr");
                if (op == 7'b0000011) begin
                    for (int i = 0; i <= mw; i++) begin
                        rdy = (i == mw);
                        cyc($urandom, rdy, $urandom, 1'b1,
                            mk(1, 0, 1, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0), "mem_read");
                    end
                    check_now(mk(0, 0, 0, 0, 0, 1, 2'b00, 3'b000, 2'b00, 2'b00, 2'b01, 0),
                              "wait_expired");
                    cyc($urandom, 1'($urandom), $urandom, 1'b1,
                        mk(0, 0, 0, 0, 0, 1, 2'b00, 3'b000, 2'b00, 2'b00, 2'b01, 0), "mem_wb");
                end else begin
                    for (int i = 0; i <= mw; i++) begin
                        if (i == abort) begin
                            do_reset();
                            return;
                        end
                        rdy = (i == mw);
                        cyc($urandom, rdy, $urandom, 1'b1,
                            mk(1, 1, 1, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0), "mem_write");
                    end
                end
            end
            7'b1100011: begin
                alu = br_zero ? 32'd0 : ($urandom | 32'd1);
                rdy = (f3 == 3'b000 && br_zero) || (f3 == 3'b001 && !br_zero);
                cyc($urandom, 1'($urandom), alu, 1'b1,
                    mk(0, 0, 0, 0, rdy, 0, 2'b11, 3'b000, 2'b10, 2'b00, 2'b00, 0), "branch");
            end
            7'b1101111: begin
                cyc($urandom, 1'($urandom), $urandom, 1'b1,
                    mk(0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b01, 2'b10, 2'b00, 0), "jal");
                cyc($urandom, 1'($urandom), $urandom, 1'b1,
                    mk(0, 0, 0, 0, 0, 1, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0), "alu_wb");
            end
            default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                for (int i = 0; i < 3; i++) begin
                    cyc($urandom, 1'($urandom), $urandom, 1'b1, 18'd1, "trap");
                end
                do_reset();
`endif
            end
        endcase
    endtask

    function automatic bit legal_op(input logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
               op == 7'b0100011 || op == 7'b1100011 || op == 7'b1101111;
    endfunction

    initial begin
        logic [31:0] instr;
        logic [6:0]  op;
        int          k, fw, mw, abort;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(32'h002081B3, 0, 0, 1'b0, -1);                                  // add
        run_instr({7'b0100000, 5'd3, 5'd1, 3'b101, 5'd2, 7'b0010011}, 0, 0, 1'b0, -1); // srai
        run_instr({12'd5, 5'd1, 3'b010, 5'd2, 7'b0010011}, 1, 0, 1'b0, -1);          // slti
        run_instr({12'd8, 5'd1, 3'b010, 5'd2, 7'b0000011}, 0, 3, 1'b0, -1);          // lw, 3 wait
        run_instr({7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011}, 0, 0, 1'b1, -1);     // beq taken
        run_instr({7'd0, 5'd2, 5'd1, 3'b001, 5'd0, 7'b1100011}, 0, 0, 1'b1, -1);     // bne not taken
        run_instr({7'd0, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0100011}, 0, 5, 1'b0, 2);      // sw, reset mid-write
        run_instr(32'h0000007F, 0, 0, 1'b0, -1);                                  // illegal
        run_instr({20'h00010, 5'd1, 7'b1101111}, 2, 0, 1'b0, -1);                  // jal

        repeat (300) begin
            k = $urandom_range(0, 6);
            case (k)
                0: op = 7'b0110011;
                1: op = 7'b0010011;
                2: op = 7'b0000011;
                3: op = 7'b0100011;
                4: op = 7'b1100011;
                5: op = 7'b1101111;
                default: begin
                    op = 7'($urandom);
                    while (legal_op(op)) op = 7'($urandom);
                end
            endcase
            instr = $urandom;
            instr[6:0] = op;
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 3);
            abort = ($urandom_range(0, 7) == 0) ? $urandom_range(0, mw) : -1;
            run_instr(instr, fw, mw, 1'($urandom), abort);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
